// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to the transmitter and receiver, byte size and defaults.
// Default configuration for the 32-bit receive path.
package uart_pkg;
  localparam logic [1:0] IDLE  = 2'h0;
  localparam logic [1:0] START = 2'h1;
  localparam logic [1:0] DATA  = 2'h2;
  localparam logic [1:0] STOP  = 2'h3;

  localparam int BITS_PER_BYTE    = 8;
  localparam int OVERSAMPLE_DEF   = 16;
  localparam int WORD_BYTES_DEF   = 4;
  localparam int TIMEOUT_BITS_DEF = 20;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rxd synchroniser, start/data/stop FSM, byte_ok/byte_err pulse in the mid-stop rxen cycle.
// Latency: byte_ok/byte_err are combinational in the rxen cycle that samples the stop bit; no backpressure.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxen,
  input  logic       rxd,
  output logic [7:0] byte_dat,
  output logic       byte_ok,
  output logic       byte_err,
  output logic [1:0] state
);
  localparam int SW = cnt_w(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(BITS_PER_BYTE - 1);

  logic          rxd_meta_q, rxd_meta_d;
  logic          rxd_s_q, rxd_s_d;
  logic          rxd_prev_q, rxd_prev_d;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sample_cnt_q, sample_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;

  always_comb begin
    rxd_meta_d   = rxd;
    rxd_s_d      = rxd_meta_q;
    rxd_prev_d   = rxd_prev_q;
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_ok      = 1'b0;
    byte_err     = 1'b0;
    if (rxen) begin
      // Edge history is kept at tick rate, so a line still low after a bad stop bit never looks like a new start.
      rxd_prev_d = rxd_s_q;
      case (state_q)
        IDLE: begin
          if (rxd_prev_q && !rxd_s_q) begin
            state_d      = START;
            sample_cnt_d = '0;
          end
        end
        START: begin
          if (sample_cnt_q == HALF_LAST) begin
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
            state_d      = rxd_s_q ? IDLE : DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
        DATA: begin
          if (sample_cnt_q == FULL_LAST) begin
            sample_cnt_d = '0;
            shreg_d      = {rxd_s_q, shreg_q[7:1]};
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
        default: begin
          if (sample_cnt_q == FULL_LAST) begin
            sample_cnt_d = '0;
            byte_ok      = rxd_s_q;
            byte_err     = !rxd_s_q;
            state_d      = IDLE;
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_prev_q   <= 1'b1;
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
    end else begin
      rxd_meta_q   <= rxd_meta_d;
      rxd_s_q      <= rxd_s_d;
      rxd_prev_q   <= rxd_prev_d;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
    end
  end

  assign byte_dat = shreg_q;
  assign state    = state_q;
endmodule

// File: rtl/uart_rx32.sv
// UART word receiver: assembles WORD_BYTES 8N1 bytes (byte 0 in the LSBs); optional idle timeout via UART_RX_TIMEOUT_EN.
// Latency: valid/frame_err 1 clk after the stop-bit rxen tick; no backpressure, words must be taken when valid pulses.
module uart_rx32
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int WORD_BYTES = WORD_BYTES_DEF
`ifdef UART_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      rxen,
  input  logic                      rxd,
  output logic [8*WORD_BYTES-1:0]   rx_data,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      rx_busy
);
  localparam int WW = BITS_PER_BYTE * WORD_BYTES;
  localparam int CW = cnt_w(WORD_BYTES);
  localparam logic [CW-1:0] LAST_LANE = CW'(WORD_BYTES - 1);

  logic [7:0]    byte_dat;
  logic          byte_ok;
  logic          byte_err;
  logic [1:0]    state;
  logic          timeout_fire;

  logic [WW-1:0] word_q, word_d;
  logic [WW-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;

  uart_rx_byte #(.OVERSAMPLE(OVERSAMPLE)) u_byte (
    .clk      (clk),
    .n_rst    (n_rst),
    .rxen     (rxen),
    .rxd      (rxd),
    .byte_dat (byte_dat),
    .byte_ok  (byte_ok),
    .byte_err (byte_err),
    .state    (state)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TW    = cnt_w(LIMIT);

  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d   = idle_cnt_q;
    timeout_fire = 1'b0;
    if (state != IDLE || byte_cnt_q == '0) begin
      idle_cnt_d = '0;
    end else if (rxen) begin
      if (idle_cnt_q == TW'(LIMIT - 1)) begin
        timeout_fire = 1'b1;
        idle_cnt_d   = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    word_d      = word_q;
    rx_data_d   = rx_data_q;
    byte_cnt_d  = byte_cnt_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    if (byte_ok) begin
      word_d[int'(byte_cnt_q)*BITS_PER_BYTE +: BITS_PER_BYTE] = byte_dat;
      if (byte_cnt_q == LAST_LANE) begin
        rx_data_d  = word_d;
        valid_d    = 1'b1;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + CW'(1);
      end
    end else if (byte_err || timeout_fire) begin
      // Stale lanes in word_q are harmless: every lane is rewritten before the next valid.
      frame_err_d = 1'b1;
      byte_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_q      <= '0;
      rx_data_q   <= '0;
      byte_cnt_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      word_q      <= word_d;
      rx_data_q   <= rx_data_d;
      byte_cnt_q  <= byte_cnt_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state != IDLE) || (byte_cnt_q != '0);
endmodule

// File: doc/uart_rx32.md
Name: uart_rx32

Overview:
- UART receiver that sits directly opposite the 32-bit UART transmitter on the serial link.
- Samples rxd with an oversampling tick and deserialises 8N1 frames (LSB first).
- Assembles 4 consecutive bytes into one 32-bit word; byte 0 lands in bits [7:0], matching the transmitter's byte order.
- Presents the word with a 1-cycle valid pulse to the downstream calculator logic.

Parameters:
- OVERSAMPLE, 16, rxen ticks per bit period; even, >= 4.
- WORD_BYTES, 4, bytes per assembled word; rx_data width = 8*WORD_BYTES.
- TIMEOUT_BITS, 20, bit periods of line idle before a partial word is discarded (optional feature only).

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- rxen  input  1  oversampling tick, 1-cycle pulse at OVERSAMPLE x baud
- rxd  input  1  serial input, idles high, asynchronous to clk
- rx_data  output  32  assembled word, held until next word completes
- valid  output  1  1-cycle pulse, rx_data updated in the same cycle
- frame_err  output  1  1-cycle pulse on a bad stop bit
- rx_busy  output  1  high when the state is not IDLE or a partial word is held

Behaviour:
- Interface: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: rx_data=0, valid=0, frame_err=0, rx_busy=0, state=IDLE, byte_cnt=0, sample_cnt=0, bit_cnt=0. The synchroniser flops reset to 1.
- rxd passes through a 2-flop synchroniser; all logic uses the synchronised value rxd_s. An edge detect uses the previous rxd_s.
- Counters advance only on cycles where rxen=1.
- IDLE:
  - A falling edge on rxd_s (1->0) moves to START and clears sample_cnt.
  - A level-low line after a framing error is not treated as a start; a new 1->0 edge is required.
- START:
  - At sample_cnt = OVERSAMPLE/2-1, sample rxd_s.
  - If the sample is 0, go to DATA and clear sample_cnt and bit_cnt.
  - If the sample is 1, this is a false start: return to IDLE with no flags.
- DATA:
  - Sample rxd_s every OVERSAMPLE ticks, which is mid-bit.
  - Shift each sample into the byte register from the MSB side, giving LSB first.
  - After the 8th bit, go to STOP.
- STOP (sampled after OVERSAMPLE ticks):
  - If the sample is 1: write the byte into word lane byte_cnt.
    - If byte_cnt == WORD_BYTES-1: load rx_data, pulse valid, and set byte_cnt=0.
    - Otherwise, increment byte_cnt.
  - If the sample is 0: pulse frame_err, discard the partial word, and set byte_cnt=0.
  - Either way, return to IDLE.
- Latency: valid rises 1 clk after the rxen tick that samples the last stop bit.
- Back-to-back frames are accepted because IDLE re-arms immediately after the mid-stop sample.
- Asynchronous reset mid-frame aborts the frame and clears any partial word. No valid is produced for that frame.
- valid and frame_err are never high in the same cycle.
- rx_data is not modified by a framing error.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- With the macro:
  - An idle counter runs in IDLE while byte_cnt != 0.
  - When it reaches TIMEOUT_BITS*OVERSAMPLE ticks, byte_cnt clears (partial word dropped) and frame_err pulses once.
  - Any start edge clears the counter.
- Without the macro: a partial word is held indefinitely until the remaining bytes arrive. No counter logic is synthesised.

Decomposition:
- Package uart_pkg holds:
  - the state encoding: IDLE=2'h0, START=2'h1, DATA=2'h2, STOP=2'h3, shared with the transmitter;
  - BITS_PER_BYTE=8;
  - default OVERSAMPLE and WORD_BYTES.
- Sub-module uart_rx_byte: synchroniser, bit FSM, byte output with byte_ok and byte_err pulses.
- uart_rx32 wraps uart_rx_byte with the word-assembly counter and the timeout logic.

Test Plan:
- Send the 4 bytes of 32'hA5C3_0F81 (81,0F,C3,A5) at OVERSAMPLE=16 -> exactly one valid pulse, rx_data=32'hA5C3_0F81, frame_err never high.
- Loopback from the transmitter with tx_data=32'h1234_5678 and valid, with rxen/txen derived from the same divider -> rx_data=32'h1234_5678 after 40 bit periods.
- Send 2 good bytes, then a byte with stop bit 0, then 4 good bytes of 32'hDEAD_BEEF -> one frame_err pulse, then valid with rx_data=32'hDEAD_BEEF. rx_data is unchanged at the frame_err.
- Send a 0 glitch on rxd of 4 oversample ticks in IDLE -> state returns to IDLE, no valid, no frame_err, byte_cnt=0.
- Assert n_rst low mid-DATA of byte 2, then send a full word 32'h0000_00FF -> all outputs 0 during reset, then valid with 32'h0000_00FF.
- With UART_RX_TIMEOUT_EN defined, send 1 byte and then 20 idle bit periods -> frame_err pulses once, and the next 4 bytes produce a correct word.
